imm_ext_pipe: RTL and testbench

Parametrised, two-stage pipelined immediate-extension unit for the MIPS datapath. It takes a raw immediate field plus an extension mode from decode and returns a full-width operand: sign-extend, zero-extend, LUI placement, or branch offset. Valid/ready handshaking on both sides lets it sit between decode and the ID/EX register with stall and flush support. It replaces purely combinational sign extension where the pipelined core needs a registered, back-pressure-aware operand path.

---
 rtl/imm_ext_pipe.sv | 93 +++++++++
 tb/tb_imm_ext_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage valid/ready immediate extender (SEXT/ZEXT/LUI/BRANCH)
// with flush, back-pressure and a saturating illegal-mode counter.
module imm_ext_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [7:0]       illegal_cnt
);
    logic             r_s1_full;
    logic             r_s2_full;
    logic [IN_W-1:0]  r_s1_imm;
    logic [2:0]       r_s1_mode;
    logic [TAG_W-1:0] r_s1_tag;
    logic [OUT_W-1:0] r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_err;
    logic [7:0]       r_cnt;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_in_xfer;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_res;

    assign w_s2_adv    = !r_s2_full || out_ready;
    assign w_s1_adv    = !r_s1_full || w_s2_adv;
    assign in_ready    = !flush && w_s1_adv;
    assign w_in_xfer   = in_valid && in_ready;
    assign out_valid   = r_s2_full;
    assign out_data    = r_out_data;
    assign out_tag     = r_out_tag;
    assign out_err     = r_out_err;
    assign illegal_cnt = r_cnt;

    // Shift-based forms avoid zero-width replications when OUT_W == IN_W.
    always_comb begin
        w_zext = OUT_W'(r_s1_imm);
        w_sext = w_zext | ({OUT_W{r_s1_imm[IN_W-1]}} << IN_W);
        w_res  = (r_s1_mode == 3'd0) ? w_sext :
                 (r_s1_mode == 3'd1) ? w_zext :
                 (r_s1_mode == 3'd2) ? (w_zext << (OUT_W - IN_W)) :
                 (r_s1_mode == 3'd3) ? (w_sext << BR_SHIFT) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_full  <= 1'b0;
            r_s2_full  <= 1'b0;
            r_s1_imm   <= '0;
            r_s1_mode  <= '0;
            r_s1_tag   <= '0;
            r_out_data <= '0;
            r_out_tag  <= '0;
            r_out_err  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (flush) begin
                r_s1_full <= 1'b0;
                r_s2_full <= 1'b0;
            end else begin
                if (w_s2_adv) r_s2_full <= r_s1_full;
                if (w_s1_adv) r_s1_full <= in_valid;
            end
            if (w_in_xfer) begin
                r_s1_imm  <= in_imm;
                r_s1_mode <= in_mode;
                r_s1_tag  <= in_tag;
            end
            // Output registers only move when S2 advances, keeping them stable under stall.
            if (w_s2_adv && r_s1_full) begin
                r_out_data <= w_res;
                r_out_tag  <= r_s1_tag;
                r_out_err  <= r_s1_mode[2];
            end
            if (w_in_xfer && in_mode[2] && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed vectors with a queue scoreboard and decoupled output monitors
// for the default configuration and a 12->24 bit, BR_SHIFT=1 variant.
module tb_imm_ext_pipe;
    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        logic        e;
        logic        lat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [2:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;
    logic [7:0]  illegal_cnt;

    logic        v_in_valid = 1'b0;
    logic        v_in_ready;
    logic [11:0] v_in_imm = '0;
    logic [2:0]  v_in_mode = '0;
    logic [4:0]  v_in_tag = '0;
    logic        v_out_valid;
    logic [23:0] v_out_data;
    logic [4:0]  v_out_tag;
    logic        v_out_err;
    logic [7:0]  v_illegal_cnt;

    exp_t q[$];
    exp_t q2[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    imm_ext_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_err(out_err),
        .illegal_cnt(illegal_cnt)
    );

    imm_ext_pipe #(.IN_W(12), .OUT_W(24), .BR_SHIFT(1), .TAG_W(5)) dut_v (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .in_imm(v_in_imm), .in_mode(v_in_mode), .in_tag(v_in_tag), .out_valid(v_out_valid),
        .out_ready(1'b1), .out_data(v_out_data), .out_tag(v_out_tag), .out_err(v_out_err),
        .illegal_cnt(v_illegal_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got data 0x%0h tag %0d, expected no output", out_data, out_tag);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_tag", 32'(out_tag), 32'(e.t));
                chk("out_err", 32'(out_err), 32'(e.e));
                if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && v_out_valid) begin
            if (q2.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL v_unexpected_output: got data 0x%0h, expected no output", v_out_data);
            end else begin
                e = q2.pop_front();
                chk("v_out_data", 32'(v_out_data), e.d);
                chk("v_out_tag", 32'(v_out_tag), 32'(e.t));
                chk("v_latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
    end

    // Caller is aligned just after a rising edge; returns likewise after acceptance.
    task automatic send(input logic [15:0] imm, input logic [2:0] mode, input logic [4:0] tag,
                        input logic [31:0] d, input logic err, input logic lat);
        in_imm = imm;
        in_mode = mode;
        in_tag = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{d, tag, err, lat, cyc});
                @(posedge clk);
                #1 in_valid = 1'b0;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q.size() != 0 || q2.size() != 0); i++) @(posedge clk);
        chk("drain_pending", 32'(q.size() + q2.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // mode sweep, back-to-back with out_ready high
        send(16'h8001, 3'd0, 5'd1, 32'hFFFF8001, 1'b0, 1'b1);
        send(16'h8001, 3'd1, 5'd2, 32'h00008001, 1'b0, 1'b1);
        send(16'h8001, 3'd2, 5'd3, 32'h80010000, 1'b0, 1'b1);
        send(16'h8001, 3'd3, 5'd4, 32'hFFFE0004, 1'b0, 1'b1);
        send(16'h7FFF, 3'd0, 5'd5, 32'h00007FFF, 1'b0, 1'b1);
        send(16'h0001, 3'd3, 5'd6, 32'h00000004, 1'b0, 1'b1);
        drain();

        // illegal modes and saturation
        send(16'h1234, 3'd5, 5'd7, 32'h0, 1'b1, 1'b1);
        drain();
        chk("illegal_cnt_1", 32'(illegal_cnt), 32'd1);
        for (int i = 0; i < 300; i++) send(16'(i), 3'(4 + i % 4), 5'(i), 32'h0, 1'b1, 1'b0);
        drain();
        chk("illegal_cnt_sat", 32'(illegal_cnt), 32'd255);

        // back-pressure: two entries held, third waits
        out_ready = 1'b0;
        send(16'h00FF, 3'd0, 5'd8, 32'h000000FF, 1'b0, 1'b0);
        send(16'hFF00, 3'd1, 5'd9, 32'h0000FF00, 1'b0, 1'b0);
        in_imm = 16'h0003;
        in_mode = 3'd3;
        in_tag = 5'd10;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", out_data, 32'h000000FF);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        q.push_back('{32'h0000000C, 5'd10, 1'b0, 1'b0, cyc});
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // flush with both stages full
        out_ready = 1'b0;
        send(16'h0001, 3'd0, 5'd11, 32'h1, 1'b0, 1'b0);
        send(16'h0002, 3'd0, 5'd12, 32'h2, 1'b0, 1'b0);
        in_imm = 16'h0003;
        in_mode = 3'd6;
        in_tag = 5'd13;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_illegal_cnt", 32'(illegal_cnt), 32'd255);
        send(16'h0010, 3'd0, 5'd14, 32'h00000010, 1'b0, 1'b1);
        drain();

        // async reset mid-stream
        send(16'h8000, 3'd0, 5'd15, 32'hFFFF8000, 1'b0, 1'b0);
        send(16'h0004, 3'd1, 5'd16, 32'h00000004, 1'b0, 1'b0);
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_out_tag", 32'(out_tag), 32'd0);
        chk("arst_out_err", 32'(out_err), 32'd0);
        chk("arst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(16'h0020, 3'd2, 5'd17, 32'h00200000, 1'b0, 1'b1);
        drain();

        // 12->24 bit variant, BR_SHIFT=1
        v_in_imm = 12'h800;
        v_in_mode = 3'd3;
        v_in_tag = 5'd18;
        v_in_valid = 1'b1;
        @(negedge clk);
        chk("v_in_ready", 32'(v_in_ready), 32'd1);
        q2.push_back('{32'h00FFF000, 5'd18, 1'b0, 1'b1, cyc});
        @(posedge clk);
        #1;
        v_in_mode = 3'd2;
        v_in_tag = 5'd19;
        @(negedge clk);
        q2.push_back('{32'h00800000, 5'd19, 1'b0, 1'b1, cyc});
        @(posedge clk);
        #1 v_in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
